// File: rtl/sb_pkg.sv
// Shared types and constants for the posted-write store buffer.
// Entries hold the word address, lane-replicated data and byte mask.
package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] addr_w;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational youngest-wins byte-lane merge of pending stores
// against a load word address.
module sb_fwd_merge
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         rd_ptr,
    input  logic [29:0]           ld_addr_w,
    output logic [3:0]            fwd_mask,
    output logic [31:0]           fwd_data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so younger matches overwrite older lanes.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        idx      = '0;
        for (int a = 0; a < DEPTH; a++) begin
            idx = rd_ptr + PW'(a);
            if (valid[idx] && entries[idx].addr_w == ld_addr_w) begin
                for (int l = 0; l < 4; l++) begin
                    if (entries[idx].mask[l]) begin
                        fwd_mask[l]        = 1'b1;
                        fwd_data[l*8 +: 8] = entries[idx].data[l*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory,
// with in-order drain and per-byte load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_mask,
    input  logic [31:0] ld_addr,
    output logic [3:0]  ld_fwd_mask,
    output logic [31:0] ld_fwd_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_mask,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] slots;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         age;
    logic                  push;
    logic                  pop;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = count < CW'(DEPTH);
    assign mem_req  = count != '0;
    assign empty    = count == '0;
    assign push     = st_valid & st_ready;
    assign pop      = mem_req & mem_ack;

    assign mem_addr = {slots[rd_ptr].addr_w, 2'b00};
    assign mem_data = slots[rd_ptr].data;
    assign mem_mask = slots[rd_ptr].mask;

    // An entry is live when its distance from the head is below count.
    always_comb begin
        valid = '0;
        age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - rd_ptr;
            valid[i] = CW'(age) < count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= '{addr_w: st_addr[31:2],
                                   data:   st_data,
                                   mask:   st_mask};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    sb_fwd_merge #(
        .DEPTH(DEPTH)
    ) u_fwd (
        .entries  (slots),
        .valid    (valid),
        .rd_ptr   (rd_ptr),
        .ld_addr_w(ld_addr[31:2]),
        .fwd_mask (ld_fwd_mask),
        .fwd_data (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue model.
// Model state is the ordered list of pending stores.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] ld_addr;
    logic [3:0]  ld_fwd_mask;
    logic [31:0] ld_fwd_data;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_mask;
    logic        empty;

    int checks = 0;
    int fails  = 0;

    sb_entry_t q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_mask    (st_mask),
        .ld_addr    (ld_addr),
        .ld_fwd_mask(ld_fwd_mask),
        .ld_fwd_data(ld_fwd_data),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_mask   (mem_mask),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0]  em;
        logic [31:0] ed;
        em = '0;
        ed = '0;
        foreach (q[i]) begin
            if (q[i].addr_w == ld_addr[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (q[i].mask[l]) begin
                        em[l]       = 1'b1;
                        ed[l*8 +: 8] = q[i].data[l*8 +: 8];
                    end
                end
            end
        end
        chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, {q[0].addr_w, 2'b00});
            chk("mem_data", mem_data, q[0].data);
            chk("mem_mask", 32'(mem_mask), 32'(q[0].mask));
        end
        chk("fwd_mask", 32'(ld_fwd_mask), 32'(em));
        chk("fwd_data", ld_fwd_data, ed);
    endtask

    // One clock: drive, check before the edge, advance the model at the edge.
    task automatic step(input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic ack, input logic [31:0] la,
                        input logic rst);
        bit pu;
        bit po;
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        mem_ack  = ack;
        ld_addr  = la;
        reset    = rst;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        pu = v && (q.size() < DEPTH);
        po = ack && (q.size() != 0);
        if (rst) begin
            q.delete();
        end else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back('{addr_w: a[31:2], data: d, mask: m});
        end
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 32'h0, 32'h0, 4'h0, ack, 32'h0, 1'b0);
    endtask

    initial begin
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mask  = '0;
        mem_ack  = 1'b0;
        ld_addr  = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle, with stray acks.
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_fwd", 32'(ld_fwd_mask), 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Single store, stalled, then popped.
        step(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        chk("lat_req", 32'(mem_req), 32'd1);
        chk("lat_addr", mem_addr, 32'h100);
        chk("lat_data", mem_data, 32'hDEADBEEF);
        repeat (5) idle(1'b0);
        idle(1'b1);
        chk("pop_empty", 32'(empty), 32'd1);

        // Fill to full, refuse a fifth, free one slot, drain.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h200 + 32'(i * 4), 32'h1111_0000 + 32'(i),
                 4'(i + 1), 1'b0, 32'h0, 1'b0);
        end
        chk("full_ready", 32'(st_ready), 32'd0);
        step(1'b1, 32'h300, 32'hBAD0BAD0, 4'hF, 1'b0, 32'h0, 1'b0);
        idle(1'b1);
        chk("ready_back", 32'(st_ready), 32'd1);
        chk("order_addr", mem_addr, 32'h204);
        repeat (4) idle(1'b1);

        // Youngest-wins lane merge.
        step(1'b1, 32'h40, 32'h000000AA, 4'b0001, 1'b0, 32'h43, 1'b0);
        step(1'b1, 32'h40, 32'hBB00BB00, 4'b1010, 1'b0, 32'h43, 1'b0);
        ld_addr = 32'h43;
        #1;
        chk("fwd43_mask", 32'(ld_fwd_mask), 32'b1011);
        chk("fwd43_data", ld_fwd_data, 32'hBB00BBAA);
        ld_addr = 32'h44;
        #1;
        chk("fwd44_mask", 32'(ld_fwd_mask), 32'b0000);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 1'b0);
        idle(1'b0);

        // Steady state: push and pop every cycle at count 2.
        step(1'b1, 32'h500, 32'hA0A0A0A0, 4'hF, 1'b0, 32'h500, 1'b0);
        step(1'b1, 32'h504, 32'hA1A1A1A1, 4'hF, 1'b0, 32'h504, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h508 + 32'(i * 4), $urandom, 4'($urandom),
                 1'b1, 32'h500 + 32'($urandom_range(0, 10) * 4), 1'b0);
        end
        chk("steady_cnt", 32'(q.size()), 32'd2);
        repeat (2) idle(1'b1);

        // Reset while holding entries.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h600, 32'h0F0F0F0F, 4'hF, 1'b0, 32'h600, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h600, 1'b1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_fwd", 32'(ld_fwd_mask), 32'd0);
        step(1'b1, 32'h700, 32'h12345678, 4'h3, 1'b0, 32'h700, 1'b0);
        idle(1'b1);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 9) < 6,
                 32'h80 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom),
                 $urandom_range(0, 1) == 1,
                 32'h80 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3)),
                 $urandom_range(0, 99) == 0);
        end
        repeat (DEPTH + 1) idle(1'b1);
        chk("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a data memory that may take several cycles per write. The core posts stores (word address, lane-replicated data, byte mask) and proceeds without stalling unless the buffer is full. Entries drain in order to memory over a req/ack handshake. Loads see pending stores through per-byte, youngest-wins forwarding, which the core merges over the memory read data.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- st_valid  in  1  core presents a store this cycle.
- st_ready  out  1  buffer can accept a store; equals count < DEPTH.
- st_addr  in  32  byte address; bits [1:0] ignored.
- st_data  in  32  write data, already replicated across byte lanes.
- st_mask  in  4  byte-enable mask; bit i enables byte lane i.
- ld_addr  in  32  load byte address for the forwarding lookup.
- ld_fwd_mask  out  4  bit i set when some pending store covers lane i of the ld_addr word.
- ld_fwd_data  out  32  forwarded bytes; lanes with ld_fwd_mask=0 are 0.
- mem_req  out  1  head entry presented to memory.
- mem_ack  in  1  memory accepts the head write this cycle.
- mem_addr  out  32  {head word address, 2'b00}.
- mem_data  out  32  head entry data.
- mem_mask  out  4  head entry mask.
- empty  out  1  count == 0; used by the core/testbench for fences and end-of-test.

## Operation
- Storage is a circular FIFO.
  - Each entry holds addr[31:2], data and mask.
  - Pointers wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is $clog2(DEPTH+1) bits wide.
- Enqueue happens on push = st_valid & st_ready.
  - The entry is written at wr_ptr, then wr_ptr increments.
  - An entry with mask 0 is still enqueued and drained.
- Dequeue happens on pop = mem_req & mem_ack, then rd_ptr increments.
- If push and pop occur in the same cycle, count is unchanged. This is legal at count==DEPTH only if st_ready was already high, i.e. never at full: st_ready has no same-cycle bypass of a pop.
- mem_req = (count != 0).
  - mem_addr, mem_data and mem_mask come from the rd_ptr entry.
  - They hold stable while mem_req=1 and mem_ack=0.
- mem_ack while mem_req=0 is ignored.
- Forwarding compares ld_addr[31:2] against every valid entry's addr.
  - Per lane, data comes from the youngest matching entry with that mask bit set.
  - Age is (idx − rd_ptr) mod DEPTH.
  - Lookup covers stored entries only. A store arriving on st_valid in the same cycle is not forwarded.
  - The entry being popped this cycle still forwards.
- Reset, including mid-operation, discards all entries: count=0, both pointers=0.

## Timing
- Reset values: st_ready=1, mem_req=0, empty=1, ld_fwd_mask=0, ld_fwd_data=0; mem_addr/data/mask are don't-care.
- Store accepted in cycle N appears on mem_req in cycle N+1 when the buffer was empty. Minimum latency is 1 cycle.
- Drain throughput is one entry per cycle when mem_ack is held high.
- Forwarding is combinational from ld_addr. A store accepted in cycle N is forwardable from cycle N+1 until the cycle it pops, inclusive.
- Full boundary: count==DEPTH drives st_ready=0. st_ready returns to 1 the cycle after a pop.
- Empty boundary: the cycle after the last pop gives mem_req=0 and empty=1.
- No other state machine: behaviour is fully determined by count and the pointers.

## Structure
- Shared package sb_pkg:
  - typedef sb_entry_t struct {addr_w[29:0], data[31:0], mask[3:0]}.
  - Constant SB_DEPTH_DEFAULT=4.
- Sub-module sb_fwd_merge (entries, valid vector, rd_ptr, ld word address → ld_fwd_mask, ld_fwd_data): purely combinational youngest-wins lane merge. The top level keeps only the FIFO registers and the handshake.

## Test plan
- Reset then idle → st_ready=1, empty=1, mem_req=0; mem_ack pulsed while idle changes nothing.
- Push 0x100/0xDEADBEEF/1111 with mem_ack=0 → next cycle mem_req=1, mem_addr=0x100, mem_data=0xDEADBEEF, mem_mask=1111; values stay stable for 5 stalled cycles; popped on mem_ack.
- Push 4 stores with mem_ack=0 → st_ready=0 after the 4th. A 5th st_valid is not accepted. One ack → st_ready=1 next cycle. Drain order matches push order.
- Push 0x40 data 0x000000AA mask 0001, then 0x40 data 0xBB00BB00 mask 1010, stalled; ld_addr=0x43 → ld_fwd_mask=1011, ld_fwd_data=0xBB00BBAA; ld_addr=0x44 → mask 0000.
- With count=2 and mem_ack=1, push every cycle → count stays 2 and one entry retires per cycle with no loss or duplication.
- Reset asserted with 3 pending entries → next cycle empty=1, mem_req=0, ld_fwd_mask=0; a subsequent push drains normally from pointer 0.
